// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encoding and default cycle counts for the reset sequencer.
// Defaults assume the rPLL clock of 27 MHz * 37 / 7 (about 142.7 MHz).
package reset_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_RESET     = 3'd0;
   localparam state_t ST_WAIT_LOCK = 3'd1;
   localparam state_t ST_STABLE    = 3'd2;
   localparam state_t ST_PWRUP     = 3'd3;
   localparam state_t ST_INIT      = 3'd4;
   localparam state_t ST_HOLD      = 3'd5;
   localparam state_t ST_RUN       = 3'd6;
   localparam state_t ST_FAULT     = 3'd7;

   localparam int LOCK_STABLE_CYCLES_DEF  = 1024;
   // 200 us of the 27 MHz * 37 / 7 clock, rounded up to whole cycles
   localparam int SDRAM_PWRUP_CYCLES_DEF  = (27 * 37 * 200 + 6) / 7;
   localparam int CORE_HOLD_CYCLES_DEF    = 16;
   localparam int INIT_TIMEOUT_CYCLES_DEF = 65536;
   localparam int MAX_RETRIES_DEF         = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level input.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-qualified power-up reset sequencing for the SDRAM controller, core and cache.
// Build option RESET_SEQ_WATCHDOG_EN adds the SDRAM init watchdog with retries and a FAULT state.
//
// state     | meaning
// RESET     | just out of rst_n, everything held in reset
// WAIT_LOCK | waiting for synchronized PLL lock
// STABLE    | lock must stay high for LOCK_STABLE_CYCLES
// PWRUP     | SDRAM held in reset for the power-up interval
// INIT      | SDRAM released, waiting for sdram_init_done
// HOLD      | short delay before releasing the core
// RUN       | everything released, ready high
// FAULT     | init watchdog exhausted, exits only via rst_n
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
   parameter int SDRAM_PWRUP_CYCLES  = SDRAM_PWRUP_CYCLES_DEF,
   parameter int CORE_HOLD_CYCLES    = CORE_HOLD_CYCLES_DEF,
   parameter int INIT_TIMEOUT_CYCLES = INIT_TIMEOUT_CYCLES_DEF,
   parameter int MAX_RETRIES         = MAX_RETRIES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_lock,
   input  logic sdram_init_done,
   output logic sdram_rst_n,
   output logic core_rst_n,
   output logic ready,
   output logic fault
);

   // one shared down-counter sized for the longest interval it may hold
   localparam int CNT_MAX = max_int(max_int(LOCK_STABLE_CYCLES, SDRAM_PWRUP_CYCLES),
                                    max_int(max_int(CORE_HOLD_CYCLES, INIT_TIMEOUT_CYCLES),
                                            MAX_RETRIES));
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(SDRAM_PWRUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CORE_HOLD_CYCLES - 1);

   logic             lock_s;
   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             cnt_zero;

`ifdef RESET_SEQ_WATCHDOG_EN
   localparam int               RETRY_W   = $clog2(MAX_RETRIES + 1);
   localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
   localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_TIMEOUT_CYCLES - 1);

   logic [RETRY_W-1:0] retry_cnt;
   logic [RETRY_W-1:0] retry_nx;
`endif

   sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   assign cnt_zero = (cnt == '0);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
`ifdef RESET_SEQ_WATCHDOG_EN
      retry_nx = retry_cnt;
`endif
      case (state)
         ST_RESET: begin
            state_nx = ST_WAIT_LOCK;
            cnt_nx   = '0;
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_nx = ST_STABLE;
               cnt_nx   = LOCK_LOAD;
            end
         end
         ST_STABLE: begin
            if (cnt_zero) begin
               state_nx = ST_PWRUP;
               cnt_nx   = PWRUP_LOAD;
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         ST_PWRUP: begin
            if (cnt_zero) begin
               state_nx = ST_INIT;
`ifdef RESET_SEQ_WATCHDOG_EN
               cnt_nx   = INIT_LOAD;
`else
               cnt_nx   = '0;
`endif
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         ST_INIT: begin
            if (sdram_init_done) begin
               state_nx = ST_HOLD;
               cnt_nx   = HOLD_LOAD;
            end
`ifdef RESET_SEQ_WATCHDOG_EN
            else if (cnt_zero) begin
               retry_nx = retry_cnt + RETRY_ONE;
               if (int'(retry_cnt) + 1 >= MAX_RETRIES) begin
                  state_nx = ST_FAULT;
               end else begin
                  state_nx = ST_PWRUP;
                  cnt_nx   = PWRUP_LOAD;
               end
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
`endif
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               state_nx = ST_RUN;
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         ST_RUN: begin
            state_nx = ST_RUN;
         end
`ifdef RESET_SEQ_WATCHDOG_EN
         ST_FAULT: begin
            state_nx = ST_FAULT;
         end
`endif
         default: begin
            state_nx = ST_RESET;
            cnt_nx   = '0;
         end
      endcase

      // lock loss outranks every in-sequence transition; FAULT deliberately ignores it
      if (!lock_s && (state inside {ST_STABLE, ST_PWRUP, ST_INIT, ST_HOLD, ST_RUN})) begin
         state_nx = ST_WAIT_LOCK;
         cnt_nx   = '0;
`ifdef RESET_SEQ_WATCHDOG_EN
         retry_nx = '0;
`endif
      end
   end

   // outputs decode the next state so they change on the same edge as the state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_RESET;
         cnt         <= '0;
         sdram_rst_n <= 1'b0;
         core_rst_n  <= 1'b0;
         ready       <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         sdram_rst_n <= (state_nx == ST_INIT) || (state_nx == ST_HOLD) || (state_nx == ST_RUN);
         core_rst_n  <= (state_nx == ST_RUN);
         ready       <= (state_nx == ST_RUN);
      end
   end

`ifdef RESET_SEQ_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retry_cnt <= '0;
         fault     <= 1'b0;
      end else begin
         retry_cnt <= retry_nx;
         fault     <= (state_nx == ST_FAULT);
      end
   end
`else
   assign fault = 1'b0;
`endif

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences power-up resets for the fabric clocked by the rPLL output clock (~142.7 MHz from 27 MHz, 27·37/7). It qualifies the PLL lock, holds the SDRAM controller in reset for the SDRAM power-up interval, and waits for the controller's init-done handshake. Only then does it release the RISC-V core and cache. Any loss of lock returns the design to a fully reset state.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-lock-high cycles required before proceeding.
- `SDRAM_PWRUP_CYCLES`, default 28543: SDRAM reset hold, 200 µs at 142.7 MHz.
- `CORE_HOLD_CYCLES`, default 16: delay between init-done and core release.
- `INIT_TIMEOUT_CYCLES`, default 65536: init-done watchdog limit (watchdog build only).
- `MAX_RETRIES`, default 3: SDRAM init attempts before fault (watchdog build only).
- `clk` in 1: PLL output clock, the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `pll_lock` in 1: PLL LOCK, asynchronous to `clk`.
- `sdram_init_done` in 1: level from the SDRAM controller, high once the init sequence completes.
- `sdram_rst_n` out 1: synchronous active-low reset to the SDRAM controller.
- `core_rst_n` out 1: synchronous active-low reset to core and cache.
- `ready` out 1: high only in RUN.
- `fault` out 1: init watchdog exhausted; constant 0 when the watchdog is compiled out.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to become `lock_s`.
- One shared down-counter is used. Its width is `$clog2` of the largest cycle parameter, plus 1.
- States and transitions:
  - RESET → WAIT_LOCK.
  - WAIT_LOCK → STABLE when `lock_s`=1; the counter loads `LOCK_STABLE_CYCLES-1`.
  - STABLE counts down while `lock_s`=1. At 0 it → PWRUP and loads `SDRAM_PWRUP_CYCLES-1`.
  - PWRUP keeps `sdram_rst_n`=0. At 0 it → INIT with `sdram_rst_n`=1.
  - INIT → HOLD when `sdram_init_done`=1; the counter loads `CORE_HOLD_CYCLES-1`.
  - HOLD → RUN at 0, asserting `core_rst_n`=1 and `ready`=1.
  - RUN persists until lock loss or `rst_n`.
- Lock loss: `lock_s`=0 in any state after WAIT_LOCK returns the block to WAIT_LOCK. `sdram_rst_n`, `core_rst_n` and `ready` go 0 on the next edge, and the counter and retry count clear.
- Glitch during STABLE: a lock drop restarts qualification from WAIT_LOCK. There is no partial credit.
- `sdram_init_done` is ignored outside INIT. If it is already high on INIT entry, the transition to HOLD happens on the next edge.
- All outputs are registered; no combinational paths from inputs to outputs.

## Timing
- Reset values: `sdram_rst_n`=0, `core_rst_n`=0, `ready`=0, `fault`=0, state=RESET, counter=0, retry count=0.
- `rst_n` low on any edge forces RESET next cycle, including mid-sequence or in RUN.
- Lock rise to STABLE entry: 3 cycles (2 synchronizer cycles + 1 WAIT_LOCK).
- STABLE, PWRUP and HOLD each last exactly their parameter in cycles.
- `sdram_init_done` high to `core_rst_n` high: `CORE_HOLD_CYCLES`+1 cycles.
- Lock fall to resets asserted: 3 cycles.
- `core_rst_n`=1 implies `sdram_rst_n`=1. Never the reverse order.

## Configuration
- `RESET_SEQ_WATCHDOG_EN` defined:
  - INIT counts cycles. Reaching `INIT_TIMEOUT_CYCLES` without `sdram_init_done` increments the retry count and returns to PWRUP, re-asserting `sdram_rst_n`=0.
  - When the retry count reaches `MAX_RETRIES`, the block enters FAULT: `fault`=1, both resets held low.
  - FAULT exits only via `rst_n`. Lock loss does not exit FAULT.
- Undefined: INIT waits indefinitely, no FAULT state exists, and `fault` is tied 0.

## Structure
- `reset_seq_pkg` holds:
  - the state enum (RESET, WAIT_LOCK, STABLE, PWRUP, INIT, HOLD, RUN, FAULT);
  - the default cycle constants derived from the 142.7 MHz clock.
- Sub-module `sync_2ff` is the lock synchronizer and is reusable for other async inputs.

## Test plan
Bench parameters: `LOCK_STABLE_CYCLES`=8, `SDRAM_PWRUP_CYCLES`=20, `CORE_HOLD_CYCLES`=4, `INIT_TIMEOUT_CYCLES`=50, `MAX_RETRIES`=2.
- Nominal: lock rises at cycle 10 and init_done rises 5 cycles after `sdram_rst_n` rises → `sdram_rst_n` rises at cycle 41, `core_rst_n`/`ready` at cycle 51.
- Lock glitch: lock low for 1 cycle during STABLE → `sdram_rst_n` stays 0 and qualification restarts (full 8 cycles after the re-rise).
- Lock loss in RUN: lock falls → all three outputs 0 three cycles later, then the full sequence repeats on re-lock.
- Early init_done: `sdram_init_done` tied high → HOLD entered 1 cycle after INIT, and `core_rst_n` never precedes `sdram_rst_n`.
- Mid-sequence reset: `rst_n` low during PWRUP → all outputs reset next cycle and the sequence restarts from RESET.
- Watchdog build, init_done never high → two 50-cycle timeouts with `sdram_rst_n` re-pulsed, then `fault`=1. It persists through lock toggles and clears only on `rst_n`.
